// File: rtl/aes_tb_pkg.sv
// ============================================================================
// aes_tb_pkg : shared constants and MISR FSM state type for the AES-128 bench
// Rev 1.0
// ============================================================================
`default_nettype none

package aes_tb_pkg;

  localparam int AES_KEY_SIZE = 128;
  localparam logic [AES_KEY_SIZE-1:0] MISR_POLY_128 = 128'h87;
  localparam int DEFAULT_LATENCY = 21;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    COMPACT = 2'd2,
    DONE    = 2'd3
  } misr_state_e;

endpackage

`default_nettype wire

// File: rtl/aes_out_misr_core.sv
// ============================================================================
// misr_core : MISR signature register with seed load, enable and feedback
// Rev 1.0
// ============================================================================
`default_nettype none

module misr_core #(
  parameter int                  NUM_BITS = 128,
  parameter logic [NUM_BITS-1:0] POLY     = 128'h87,
  parameter logic [NUM_BITS-1:0] SEED     = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                en,
  input  logic [NUM_BITS-1:0] data,
  output logic [NUM_BITS-1:0] sig,
  output logic [NUM_BITS-1:0] sig_next
);

  logic [NUM_BITS-1:0] upd;

  always_comb begin
    upd = {sig[NUM_BITS-2:0], 1'b0} ^ (sig[NUM_BITS-1] ? POLY : '0) ^ data;
    sig_next = sig;
    if (load)
      sig_next = SEED;
    else if (en)
      sig_next = upd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sig <= SEED;
    else
      sig <= sig_next;
  end

endmodule

`default_nettype wire

// File: rtl/aes_out_misr.sv
// ============================================================================
// aes_out_misr : skips pipeline latency, compacts N AES output words into a
// MISR signature and holds it. Optional macro AES_MISR_CHECK_EN adds a
// golden-signature comparison (golden_sig in, pass/fail out).
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_out_misr
  import aes_tb_pkg::*;
#(
  parameter int                  NUM_BITS = AES_KEY_SIZE,
  parameter int                  LATENCY  = DEFAULT_LATENCY,
  parameter int                  COUNT_W  = 32,
  parameter logic [NUM_BITS-1:0] POLY     = MISR_POLY_128,
  parameter logic [NUM_BITS-1:0] SEED     = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [COUNT_W-1:0]  num_vectors,
  input  logic                in_en,
  input  logic [NUM_BITS-1:0] in_data,
`ifdef AES_MISR_CHECK_EN
  input  logic [NUM_BITS-1:0] golden_sig,
  output logic                pass,
  output logic                fail,
`endif
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] signature,
  output logic [COUNT_W-1:0]  vec_count
);

  localparam logic [COUNT_W-1:0] LAT_LAST = COUNT_W'(LATENCY - 1);

  misr_state_e         state_q, state_d;
  logic [COUNT_W-1:0]  lat_q;
  logic [COUNT_W-1:0]  nv_q;
  logic                start_ok;
  logic                absorb;
  logic [NUM_BITS-1:0] sig_next;

  assign start_ok = start && (state_q == IDLE || state_q == DONE);
  assign absorb   = (state_q == COMPACT) && in_en;
  assign busy     = (state_q == WARMUP) || (state_q == COMPACT);
  assign done     = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // With no warm-up and nothing to absorb, COMPACT could never terminate.
          if (LATENCY == 0)
            state_d = (num_vectors == '0) ? DONE : COMPACT;
          else
            state_d = WARMUP;
        end
      end
      WARMUP: begin
        if (in_en && lat_q == LAT_LAST)
          state_d = (nv_q == '0) ? DONE : COMPACT;
      end
      COMPACT: begin
        if (in_en && (vec_count + COUNT_W'(1)) == nv_q)
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      nv_q      <= '0;
      vec_count <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        lat_q     <= '0;
        nv_q      <= num_vectors;
        vec_count <= '0;
      end else begin
        if (state_q == WARMUP && in_en)
          lat_q <= lat_q + COUNT_W'(1);
        if (absorb)
          vec_count <= vec_count + COUNT_W'(1);
      end
    end
  end

  misr_core #(
    .NUM_BITS (NUM_BITS),
    .POLY     (POLY),
    .SEED     (SEED)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_ok),
    .en       (absorb),
    .data     (in_data),
    .sig      (signature),
    .sig_next (sig_next)
  );

`ifdef AES_MISR_CHECK_EN
  // Compare against the value being written so the verdict lands with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass <= 1'b0;
      fail <= 1'b0;
    end else if (start_ok) begin
      pass <= 1'b0;
      fail <= 1'b0;
    end else if (state_d == DONE && state_q != DONE) begin
      pass <= (sig_next == golden_sig);
      fail <= (sig_next != golden_sig);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_out_misr.sv
// ============================================================================
// tb_aes_out_misr : scoreboard bench for aes_out_misr (two parameter sets)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_aes_out_misr;

  typedef struct {
    logic [127:0] sig;
    logic [31:0]  vc;
    bit           pass;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_a = 1'b0, start_b = 1'b0;
  logic [31:0]  nv_a = '0, nv_b = '0;
  logic         en_a = 1'b0, en_b = 1'b0;
  logic [127:0] data_a = '0, data_b = '0;
  logic [127:0] golden_a = '0, golden_b = '0;
  logic         busy_a, done_a, busy_b, done_b;
  logic         pass_a, fail_a, pass_b, fail_b;
  logic [127:0] sig_a, sig_b;
  logic [31:0]  vc_a, vc_b;

  int   checks = 0;
  int   failures = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic done_a_prev = 1'b0, done_b_prev = 1'b0;

  always #5 clk = ~clk;

  aes_out_misr #(.LATENCY(2), .SEED(128'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .num_vectors(nv_a),
    .in_en(en_a), .in_data(data_a),
`ifdef AES_MISR_CHECK_EN
    .golden_sig(golden_a), .pass(pass_a), .fail(fail_a),
`endif
    .busy(busy_a), .done(done_a), .signature(sig_a), .vec_count(vc_a));

  aes_out_misr #(.LATENCY(0), .SEED({1'b1, 127'h0})) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .num_vectors(nv_b),
    .in_en(en_b), .in_data(data_b),
`ifdef AES_MISR_CHECK_EN
    .golden_sig(golden_b), .pass(pass_b), .fail(fail_b),
`endif
    .busy(busy_b), .done(done_b), .signature(sig_b), .vec_count(vc_b));

`ifndef AES_MISR_CHECK_EN
  assign pass_a = 1'b0;
  assign fail_a = 1'b0;
  assign pass_b = 1'b0;
  assign fail_b = 1'b0;
`endif

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [127:0] s,
                         input logic [31:0] v, input logic p, input logic f);
    chk({tag, " signature"}, s, e.sig);
    chk({tag, " vec_count"}, 128'(v), 128'(e.vc));
`ifdef AES_MISR_CHECK_EN
    chk({tag, " pass"}, 128'(p), 128'(e.pass));
    chk({tag, " fail"}, 128'(f), 128'(!e.pass));
`else
    if (p !== 1'b0 || f !== 1'b0) chk({tag, " tied flags"}, 128'({p, f}), 128'h0);
`endif
  endtask

  // Monitors: pop one expectation on every rising edge of done.
  always @(negedge clk) begin
    if (done_a && !done_a_prev) begin
      if (q_a.size() == 0) chk("unexpected done_a", 128'(q_a.size() + 1), 128'h0);
      else compare("run_a", q_a.pop_front(), sig_a, vc_a, pass_a, fail_a);
    end
    if (done_b && !done_b_prev) begin
      if (q_b.size() == 0) chk("unexpected done_b", 128'(q_b.size() + 1), 128'h0);
      else compare("run_b", q_b.pop_front(), sig_b, vc_b, pass_b, fail_b);
    end
    done_a_prev = done_a;
    done_b_prev = done_b;
  end

  task automatic run_a(input logic [31:0] nv, input logic [127:0] data,
                       input logic [127:0] exp_sig, input logic [31:0] exp_vc,
                       input logic [127:0] gold, input bit exp_pass, input int exp_edges);
    int edges = 0;
    q_a.push_back('{sig: exp_sig, vc: exp_vc, pass: exp_pass});
    golden_a = gold; data_a = data; en_a = 1'b1; nv_a = nv; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    chk("busy after start", 128'(busy_a), 128'h1);
    while (!done_a && edges < 100) begin
      @(posedge clk); #1 edges++;
    end
    chk("edges to done", 128'(edges), 128'(exp_edges));
    @(negedge clk);
  endtask

  task automatic wait_vc_a(input logic [31:0] target);
    int n = 0;
    while (vc_a != target && n < 100) begin
      @(posedge clk); #1 n++;
    end
    if (n >= 100) chk("wait vec_count timeout", 128'(vc_a), 128'(target));
  endtask

  initial begin
    #23;
    chk("reset busy", 128'(busy_a), 128'h0);
    chk("reset done", 128'(done_a), 128'h0);
    chk("reset signature", sig_a, 128'h0);
    chk("reset vec_count", 128'(vc_a), 128'h0);
    chk("reset signature b", sig_b, {1'b1, 127'h0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word, then two words: 1 -> (1<<1)^1 = 3
    run_a(32'd1, 128'h1, 128'h1, 32'd1, 128'h1, 1'b1, 3);
    run_a(32'd2, 128'h1, 128'h3, 32'd2, 128'h3, 1'b1, 4);
    run_a(32'd2, 128'h1, 128'h3, 32'd2, 128'h4, 1'b0, 4);
    // Nothing to absorb: done after the two warm-up edges, seed kept
    run_a(32'd0, 128'h1, 128'h0, 32'd0, 128'h0, 1'b1, 2);

    // MSB-set seed, zero data, no latency: feedback taps alone
    q_b.push_back('{sig: 128'h87, vc: 32'd1, pass: 1'b1});
    golden_b = 128'h87; data_b = '0; en_b = 1'b1; nv_b = 32'd1; start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    @(posedge clk); #1 chk("b done one edge after start", 128'(done_b), 128'h1);
    @(negedge clk);

    // Stall in COMPACT: 1, 3, 7 regardless of the gap
    q_a.push_back('{sig: 128'h7, vc: 32'd3, pass: 1'b0});
    golden_a = 128'h8; data_a = 128'h1; en_a = 1'b1; nv_a = 32'd3; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_vc_a(32'd1);
    en_a = 1'b0;
    data_a = 128'hdead;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("stall vec_count", 128'(vc_a), 128'h1);
      chk("stall signature", sig_a, 128'h1);
    end
    data_a = 128'h1;
    en_a = 1'b1;
    wait_vc_a(32'd3);
    @(negedge clk);

    // Asynchronous reset mid-COMPACT
    nv_a = 32'd3; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_vc_a(32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", 128'(busy_a), 128'h0);
    chk("async rst done", 128'(done_a), 128'h0);
    chk("async rst signature", sig_a, 128'h0);
    chk("async rst vec_count", 128'(vc_a), 128'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_a(32'd2, 128'h1, 128'h3, 32'd2, 128'h3, 1'b1, 4);

    repeat (3) @(posedge clk);
    #1;
    chk("done held signature", sig_a, 128'h3);
    chk("scoreboard a drained", 128'(q_a.size()), 128'h0);
    chk("scoreboard b drained", 128'(q_b.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
